// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath width, the NOP encoding and fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection on decode accept: jump beats branch beats sequential pc+4.
module next_pc_mux #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            sel_branch_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_raw_o
);

  logic [XLEN-1:0] target;

  always_comb begin
    target         = jump_i ? jump_target_i : branch_target_i;
    misalign_raw_o = 1'b0;
    if (jump_i || sel_branch_i) begin
      // Redirects are forced word-aligned; the dropped bits are reported instead.
      next_pc_o      = {target[XLEN-1:2], 2'b00};
      misalign_raw_o = (target[1:0] != 2'b00);
    end else begin
      next_pc_o = pc_i + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one imem request/response per instruction, handed to decode
// over valid/ready, with next-PC redirect and a sticky imem wait timeout.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel_branch,
  input  logic            jump,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            misalign,
  output logic            imem_timeout
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      wait_q, wait_d;

  logic [XLEN-1:0] next_pc;
  logic            misalign_raw;

  next_pc_mux #(
    .XLEN (XLEN)
  ) u_next_pc_mux (
    .pc_i            (pc_q),
    .sel_branch_i    (sel_branch),
    .jump_i          (jump),
    .branch_target_i (branch_target),
    .jump_target_i   (jump_target),
    .next_pc_o       (next_pc),
    .misalign_raw_o  (misalign_raw)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    timeout_d  = timeout_q;
    wait_d     = 8'd0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        req_d   = 1'b1;
      end
      StFetch: begin
        if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          req_d      = 1'b0;
          state_d    = StHold;
        end else begin
          // Saturate so the sticky flag cannot be re-armed by wraparound.
          wait_d = (wait_q == TimeoutCnt) ? wait_q : wait_q + 8'd1;
          if (wait_d == TimeoutCnt) begin
            timeout_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (valid_q && instr_ready) begin
          valid_d    = 1'b0;
          pc_d       = next_pc;
          req_d      = 1'b1;
          misalign_d = misalign_raw;
          state_d    = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC[XLEN-1:0];
      req_q      <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC[XLEN-1:0];
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      wait_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      wait_q     <= wait_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = valid_q;
  assign misalign     = misalign_q;
  assign imem_timeout = timeout_q;

endmodule
